// File: rtl/count_step_arbiter.sv
// count_step_arbiter
//   Feeds the skip/reverse count-sequence counter with 1-cycle step enables.
//   Two requesters share the counter: a periodic auto-run timer and a manual
//   pushbutton. Grants alternate round-robin on ties. After every step a
//   minimum idle gap is enforced before the next grant.
//
// Parameters
//   PERIOD_W      width of iPeriod and of the auto timer
//   GAP_CYC       idle cycles after each step (0: a step every 2nd cycle at most)
//   DEBOUNCE_CYC  stable cycles the button filter needs (CSA_DEBOUNCE_EN only)
//
// Build option
//   CSA_DEBOUNCE_EN  defined: the synchronised button must be stable for
//                    DEBOUNCE_CYC cycles before its filtered level changes.
//                    Undefined: edge detect works on the 2-flop synced level.
//
// Ports
//   iClk, iRst           clock (posedge) / synchronous active-high reset
//   iRun, iHold          auto-run enable / pause (timer frozen, no new grants)
//   iPeriod              auto step period in cycles (0 behaves as 1)
//   iAutoSkip, iAutoRev  auto qualifiers, captured when the auto request fires
//   iBtnStep             asynchronous manual step button
//   iBtnSkip, iBtnRev    manual qualifiers, captured on the button edge
//   oStep                1-cycle step enable to the counter
//   oSkip, oRev          qualifiers of the last grant (held until next grant)
//   oGrant               last granted source: 01 auto, 10 manual, 00 none
//   oBusy                high while a step is issued or the gap runs
//   oStepCount           steps issued since reset (wraps)
//   oOverrun             sticky: request dropped because the source was pending
module count_step_arbiter #(
  parameter int PERIOD_W     = 24,
  parameter int GAP_CYC      = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iRun,
  input  logic                iHold,
  input  logic [PERIOD_W-1:0] iPeriod,
  input  logic                iAutoSkip,
  input  logic                iAutoRev,
  input  logic                iBtnStep,
  input  logic                iBtnSkip,
  input  logic                iBtnRev,
  output logic                oStep,
  output logic                oSkip,
  output logic                oRev,
  output logic [1:0]          oGrant,
  output logic                oBusy,
  output logic [7:0]          oStepCount,
  output logic                oOverrun
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t              r_state;
  logic [GW-1:0]       r_gap;
  logic [PERIOD_W-1:0] r_timer;
  logic                r_sync1, r_sync2, r_btnPrev;
  logic                r_autoPend, r_autoSkip, r_autoRev;
  logic                r_manPend, r_manSkip, r_manRev;
  logic                r_lastAuto;
  logic                r_step, r_skip, r_rev, r_busy, r_overrun;
  logic [1:0]          r_grant;
  logic [7:0]          r_count;

  logic [PERIOD_W-1:0] w_periodLast;
  logic                w_autoReq, w_btnLvl, w_btnRise;
  logic                w_canGrant, w_pickMan, w_grantAuto, w_grantMan;

  assign w_periodLast = (iPeriod == '0) ? '0 : iPeriod - 1'b1;
  // ">=" so that shrinking iPeriod below the current count wraps at once
  // instead of running through the full timer range.
  assign w_autoReq    = iRun & ~iHold & (r_timer >= w_periodLast);

  always_ff @(posedge iClk) begin
    if (iRst || !iRun) begin
      r_timer <= '0;
    end else if (!iHold) begin
      r_timer <= (r_timer >= w_periodLast) ? '0 : r_timer + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= iBtnStep;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CSA_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);

  logic [DW-1:0] r_dbCnt;
  logic          r_btnFilt;

  // Counter runs only while the synced level disagrees with the filtered one.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_dbCnt   <= '0;
      r_btnFilt <= 1'b0;
    end else if (r_sync2 == r_btnFilt) begin
      r_dbCnt <= '0;
    end else if (r_dbCnt == DB_LAST) begin
      r_btnFilt <= r_sync2;
      r_dbCnt   <= '0;
    end else begin
      r_dbCnt <= r_dbCnt + 1'b1;
    end
  end

  assign w_btnLvl = r_btnFilt;
`else
  assign w_btnLvl = r_sync2;
`endif

  assign w_btnRise   = w_btnLvl & ~r_btnPrev;
  assign w_canGrant  = (r_state == S_IDLE) & ~iHold & (r_autoPend | r_manPend);
  // On a tie the source not granted last wins.
  assign w_pickMan   = r_manPend & (~r_autoPend | r_lastAuto);
  assign w_grantAuto = w_canGrant & ~w_pickMan;
  assign w_grantMan  = w_canGrant & w_pickMan;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_gap      <= '0;
      r_btnPrev  <= 1'b0;
      r_autoPend <= 1'b0;
      r_autoSkip <= 1'b0;
      r_autoRev  <= 1'b0;
      r_manPend  <= 1'b0;
      r_manSkip  <= 1'b0;
      r_manRev   <= 1'b0;
      r_lastAuto <= 1'b1;
      r_step     <= 1'b0;
      r_skip     <= 1'b0;
      r_rev      <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_grant    <= 2'b00;
      r_count    <= '0;
    end else begin
      r_btnPrev <= w_btnLvl;

      // A new request on the edge that grants the same source replaces it.
      if (w_autoReq) begin
        if (r_autoPend && !w_grantAuto) begin
          r_overrun <= 1'b1;
        end else begin
          r_autoPend <= 1'b1;
          r_autoSkip <= iAutoSkip;
          r_autoRev  <= iAutoRev;
        end
      end else if (w_grantAuto) begin
        r_autoPend <= 1'b0;
      end

      if (w_btnRise) begin
        if (r_manPend && !w_grantMan) begin
          r_overrun <= 1'b1;
        end else begin
          r_manPend <= 1'b1;
          r_manSkip <= iBtnSkip;
          r_manRev  <= iBtnRev;
        end
      end else if (w_grantMan) begin
        r_manPend <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_step <= 1'b0;
          if (w_canGrant) begin
            r_state    <= S_ISSUE;
            r_step     <= 1'b1;
            r_busy     <= 1'b1;
            r_count    <= r_count + 1'b1;
            r_lastAuto <= w_grantAuto;
            r_grant    <= w_grantAuto ? 2'b01 : 2'b10;
            r_skip     <= w_grantAuto ? r_autoSkip : r_manSkip;
            r_rev      <= w_grantAuto ? r_autoRev : r_manRev;
          end
        end
        S_ISSUE: begin
          r_step <= 1'b0;
          r_gap  <= '0;
          if (GAP_CYC > 0) begin
            r_state <= S_GAP;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_step  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oStep      = r_step;
  assign oSkip      = r_skip;
  assign oRev       = r_rev;
  assign oGrant     = r_grant;
  assign oBusy      = r_busy;
  assign oStepCount = r_count;
  assign oOverrun   = r_overrun;

endmodule

// File: tb/tb_count_step_arbiter.sv
// tb_count_step_arbiter
//   Scoreboard bench for count_step_arbiter (GAP_CYC=2, default build).
//   Stimulus pushes the expected step descriptors; a monitor pops one per
//   oStep pulse and compares grant, qualifiers, count and spacing.
module tb_count_step_arbiter;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iRun = 1'b0, iHold = 1'b0;
  logic [23:0] iPeriod = '0;
  logic        iAutoSkip = 1'b0, iAutoRev = 1'b0;
  logic        iBtnStep = 1'b0, iBtnSkip = 1'b0, iBtnRev = 1'b0;
  logic        oStep, oSkip, oRev, oBusy, oOverrun;
  logic [1:0]  oGrant;
  logic [7:0]  oStepCount;

  count_step_arbiter #(.PERIOD_W(24), .GAP_CYC(2), .DEBOUNCE_CYC(16)) dut (
    .iClk(iClk), .iRst(iRst), .iRun(iRun), .iHold(iHold), .iPeriod(iPeriod),
    .iAutoSkip(iAutoSkip), .iAutoRev(iAutoRev), .iBtnStep(iBtnStep),
    .iBtnSkip(iBtnSkip), .iBtnRev(iBtnRev), .oStep(oStep), .oSkip(oSkip),
    .oRev(oRev), .oGrant(oGrant), .oBusy(oBusy), .oStepCount(oStepCount),
    .oOverrun(oOverrun)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [1:0] grant;
    logic       skip;
    logic       rev;
    logic [7:0] count;
    int         spacing;  // cycles since previous step, 0 = not checked
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lastStepCyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] g, input logic s, input logic r,
                              input logic [7:0] c, input int sp);
    exp_t e;
    e.grant = g; e.skip = s; e.rev = r; e.count = c; e.spacing = sp;
    return e;
  endfunction

  always @(posedge iClk) cyc <= cyc + 1;

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      if (oStep === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_step", {24'd0, oStepCount}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("step_grant", {30'd0, oGrant}, {30'd0, e.grant});
          chk("step_skip", {31'd0, oSkip}, {31'd0, e.skip});
          chk("step_rev", {31'd0, oRev}, {31'd0, e.rev});
          chk("step_count", {24'd0, oStepCount}, {24'd0, e.count});
          if (e.spacing > 0) chk("step_spacing", cyc - lastStepCyc, e.spacing);
        end
        lastStepCyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic zero_inputs();
    iRun = 0; iHold = 0; iPeriod = '0; iAutoSkip = 0; iAutoRev = 0;
    iBtnStep = 0; iBtnSkip = 0; iBtnRev = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    iRst = 1;
    tick(2);
    iRst = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((q.size() != 0 || oBusy) && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  task automatic wait_step(input string name, input int budget);
    int n = 0;
    while (oStep !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, {31'd0, oStep}, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_step"}, {31'd0, oStep}, 0);
    chk({tag, "_grant"}, {30'd0, oGrant}, 0);
    chk({tag, "_count"}, {24'd0, oStepCount}, 0);
    chk({tag, "_overrun"}, {31'd0, oOverrun}, 0);
    chk({tag, "_busy"}, {31'd0, oBusy}, 0);
  endtask

  initial begin
    // Reset with random inputs
    @(negedge iClk);
    iRst = 1;
    iRun = 1'($urandom); iHold = 1'($urandom); iPeriod = 24'($urandom);
    iAutoSkip = 1'($urandom); iAutoRev = 1'($urandom);
    iBtnStep = 1'($urandom); iBtnSkip = 1'($urandom); iBtnRev = 1'($urandom);
    tick(2);
    check_reset_outputs("rst");
    zero_inputs();
    iRst = 0;

    // Tie right after reset: manual wins first, auto after the gap
    q.push_back(mk(2'b10, 1'b0, 1'b1, 8'd1, 0));
    q.push_back(mk(2'b01, 1'b1, 1'b0, 8'd2, 4));
    iBtnSkip = 0; iBtnRev = 1; iAutoSkip = 1; iAutoRev = 0; iPeriod = 24'd1;
    iBtnStep = 1;
    tick(2);
    iRun = 1;   // auto request on the same edge the manual pend sets
    tick(1);
    iRun = 0;
    tick(3);
    iBtnStep = 0;
    drain("tie_drain", 30);

    // Auto run, period 5
    do_reset();
    q.push_back(mk(2'b01, 1'b0, 1'b0, 8'd1, 0));
    q.push_back(mk(2'b01, 1'b0, 1'b0, 8'd2, 5));
    q.push_back(mk(2'b01, 1'b0, 1'b0, 8'd3, 5));
    iPeriod = 24'd5;
    iRun = 1;
    begin
      int n = 0;
      while (oStepCount != 8'd3 && n < 40) begin
        tick(1);
        n++;
      end
    end
    iRun = 0;
    chk("auto_count3", {24'd0, oStepCount}, 3);
    drain("auto_drain", 30);

    // Single manual press with both qualifiers
    do_reset();
    q.push_back(mk(2'b10, 1'b1, 1'b1, 8'd1, 0));
    iBtnSkip = 1; iBtnRev = 1; iBtnStep = 1;
    tick(6);
    iBtnStep = 0;
    drain("man_drain", 30);
    tick(10);
    chk("man_count", {24'd0, oStepCount}, 1);
    chk("man_grant", {30'd0, oGrant}, 2'b10);

    // Overrun during the gap, then hold; release serves one auto step
    q.push_back(mk(2'b10, 1'b0, 1'b0, 8'd2, 0));
    iBtnSkip = 0; iBtnRev = 0; iBtnStep = 1;
    wait_step("ovr_man_step", 20);
    iBtnStep = 0;
    iRun = 1; iPeriod = 24'd1; iAutoSkip = 1; iAutoRev = 1;
    tick(3);
    iHold = 1; iRun = 0;
    chk("ovr_overrun", {31'd0, oOverrun}, 1);
    tick(8);
    chk("hold_busy", {31'd0, oBusy}, 0);
    chk("hold_count", {24'd0, oStepCount}, 2);
    q.push_back(mk(2'b01, 1'b1, 1'b1, 8'd3, 0));
    iHold = 0;
    drain("release_drain", 20);
    tick(10);
    chk("release_count", {24'd0, oStepCount}, 3);

    // Reset in the middle of the gap with an auto request pending
    q.push_back(mk(2'b10, 1'b0, 1'b0, 8'd4, 0));
    iBtnStep = 1;
    wait_step("midrst_step", 20);
    iBtnStep = 0;
    iRun = 1; iPeriod = 24'd1;
    tick(1);
    iRun = 0;
    iRst = 1;
    tick(2);
    check_reset_outputs("midrst");
    iRst = 0;
    tick(12);
    chk("midrst_no_step", {24'd0, oStepCount}, 0);
    chk("midrst_queue", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
